// File: rtl/rsa_pkg.sv
// Shared types and constants for the rsa_modexp_core codebase slice.
// Optional feature macro used by the core: RSA_EARLY_EXIT_EN.
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRECOMP,
        CONVERT,
        LOOP,
        FINISH
    } state_t;

    localparam logic [1:0] REG_R = 2'd0;
    localparam logic [1:0] REG_M = 2'd1;
    localparam logic [1:0] REG_E = 2'd2;
    localparam logic [1:0] REG_N = 2'd3;

    // Defaults matching the core's default parameterisation.
    localparam int KEY_W_DEF  = 256;
    localparam int DATA_W_DEF = 8;
    localparam int NWORDS     = KEY_W_DEF / DATA_W_DEF;
    localparam int MM_CYC     = KEY_W_DEF / 2 + 1;

    // Per-instance versions for other parameterisations.
    function automatic int nwords(input int key_w, input int data_w);
        return key_w / data_w;
    endfunction

    function automatic int mm_cycles(input int key_w);
        return key_w / 2 + 1;
    endfunction

endpackage

// File: rtl/rsa_mont_mul.sv
// Radix-4 Montgomery multiplier: p = x*y*2^-KEY_W mod n, fully reduced.
// Handshake: go is a request accepted on any edge where the unit is idle;
// the accepting edge performs the first digit step. x, y and n must stay
// stable until rdy. rdy is high for exactly one cycle, during which p is
// valid; the edge that ends that cycle is the final-subtract cycle in which
// the consumer must capture p, and the unit returns to idle on it.
module rsa_mont_mul
    import rsa_pkg::*;
#(
    parameter int KEY_W = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [KEY_W-1:0] x,
    input  logic [KEY_W-1:0] y,
    input  logic [KEY_W-1:0] n,
    output logic             rdy,
    output logic [KEY_W-1:0] p
);

    localparam int SW   = KEY_W + 3;
    localparam int HALF = KEY_W / 2;
    localparam int CW   = $clog2(HALF + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF);

    logic [SW-1:0] s, s_cur, yx, qn, sum, tot, s_next;
    logic [CW-1:0] cnt, idx;
    logic          run;
    logic [1:0]    xi, q, lo;

    // One radix-4 digit step plus the reduced output view of S.
    always_comb begin
        idx   = run ? cnt : '0;
        s_cur = run ? s : '0;
        xi    = 2'(x >> {idx, 1'b0});
        case (xi)
            2'd0:    yx = '0;
            2'd1:    yx = SW'(y);
            2'd2:    yx = SW'(y) << 1;
            default: yx = (SW'(y) << 1) + SW'(y);
        endcase
        sum = s_cur + yx;
        // n is odd, so n^-1 mod 4 equals n mod 4.
        lo  = sum[1:0] * n[1:0];
        q   = ~lo + 2'd1;
        case (q)
            2'd0:    qn = '0;
            2'd1:    qn = SW'(n);
            2'd2:    qn = SW'(n) << 1;
            default: qn = (SW'(n) << 1) + SW'(n);
        endcase
        tot    = sum + qn;
        s_next = tot >> 2;
        rdy    = run && (cnt == LAST);
        // S < 2n, so one conditional subtract fully reduces it.
        p = (s >= SW'(n)) ? (s[KEY_W-1:0] - n) : s[KEY_W-1:0];
    end

    // Digit iteration sequencing; the rdy edge drops back to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s   <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (run) begin
            if (cnt == LAST) begin
                run <= 1'b0;
            end else begin
                s   <= s_next;
                cnt <= cnt + 1'b1;
            end
        end else if (go) begin
            s   <= s_next;
            cnt <= CW'(1);
            run <= 1'b1;
        end
    end

endmodule

// File: rtl/rsa_modexp_core.sv
// Radix-4 Montgomery modular exponentiator, R = M^E mod N, with a byte-wide
// host register port. Optional macro RSA_EARLY_EXIT_EN ends the exponent
// loop after the highest set bit of E (latency then depends on E).
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int KEY_W  = 256,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              oe,
    input  logic [1:0]        reg_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int NW = nwords(KEY_W, DATA_W);
    localparam int PW = $clog2(2 * KEY_W);
    localparam int KW = $clog2(KEY_W);
    localparam logic [ADDR_W:0] NW_LIM   = (ADDR_W + 1)'(NW);
    localparam logic [PW-1:0]   PRE_LAST = PW'(2 * KEY_W - 1);
    localparam logic [KW-1:0]   K_LAST   = KW'(KEY_W - 1);

    state_t             state;
    logic [KEY_W-1:0]   m, e, n, r, c, a, t;
    logic [PW-1:0]      pcnt;
    logic [KW-1:0]      kidx;
    logic               mm_on, inv_pend;
    logic               go0, go1, rdy0, rdy1;
    logic [KEY_W-1:0]   x0, y0, p0, p1;
    logic               addr_ok, start_ok, c_ge, last_pass;
    logic [KEY_W-1:0]   rd_reg, c_dbl;
    logic [DATA_W-1:0]  rd_word;

    // Address decode, read mux, operand validation and datapath steering.
    always_comb begin
        addr_ok = ({1'b0, addr} < NW_LIM);
        case (reg_sel)
            REG_R:   rd_reg = r;
            REG_M:   rd_reg = m;
            REG_E:   rd_reg = e;
            default: rd_reg = n;
        endcase
        rd_word  = addr_ok ? DATA_W'(rd_reg >> (int'(addr) * DATA_W)) : '0;
        start_ok = n[0] && (n >= KEY_W'(3)) && (m < n);
        // Doubling step of 2^(2*KEY_W) mod N; the difference fits KEY_W bits.
        c_dbl = {c[KEY_W-2:0], 1'b0};
        c_ge  = c[KEY_W-1] || (c_dbl >= n);
        go0   = ((state == CONVERT) || (state == LOOP)) && !mm_on;
        go1   = (state == LOOP) && !mm_on;
        x0    = (state == CONVERT) ? c : a;
        y0    = (state == CONVERT) ? m : t;
`ifdef RSA_EARLY_EXIT_EN
        last_pass = (kidx == K_LAST) || (((e >> kidx) >> 1) == '0);
`else
        last_pass = (kidx == K_LAST);
`endif
    end

    rsa_mont_mul #(.KEY_W(KEY_W)) u_mm_a (
        .clk (clk),
        .rst (reset),
        .go  (go0),
        .x   (x0),
        .y   (y0),
        .n   (n),
        .rdy (rdy0),
        .p   (p0)
    );

    rsa_mont_mul #(.KEY_W(KEY_W)) u_mm_t (
        .clk (clk),
        .rst (reset),
        .go  (go1),
        .x   (t),
        .y   (t),
        .n   (n),
        .rdy (rdy1),
        .p   (p1)
    );

    // Host writes to M, E and N; locked out while an operation runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m <= '0;
            e <= '0;
            n <= '0;
        end else if (!we && !busy && addr_ok) begin
            case (reg_sel)
                REG_M:   m[int'(addr) * DATA_W +: DATA_W] <= data_i;
                REG_E:   e[int'(addr) * DATA_W +: DATA_W] <= data_i;
                REG_N:   n[int'(addr) * DATA_W +: DATA_W] <= data_i;
                default: ;
            endcase
        end
    end

    // Registered host read data, one-cycle latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_o <= '0;
        end else if (!oe) begin
            data_o <= rd_word;
        end
    end

    // Control FSM: validate, precompute R^2 mod N, convert M, square-and-multiply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            r        <= '0;
            c        <= '0;
            a        <= '0;
            t        <= '0;
            pcnt     <= '0;
            kidx     <= '0;
            mm_on    <= 1'b0;
            inv_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (inv_pend) begin
                        done     <= 1'b1;
                        inv_pend <= 1'b0;
                    end else if (start) begin
                        if (start_ok) begin
                            busy  <= 1'b1;
                            err   <= 1'b0;
                            c     <= KEY_W'(1);
                            pcnt  <= '0;
                            state <= PRECOMP;
                        end else begin
                            err      <= 1'b1;
                            inv_pend <= 1'b1;
                        end
                    end
                end
                PRECOMP: begin
                    c    <= c_ge ? (c_dbl - n) : c_dbl;
                    pcnt <= pcnt + 1'b1;
                    if (pcnt == PRE_LAST) begin
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (go0) begin
                        mm_on <= 1'b1;
                    end else if (rdy0) begin
                        mm_on <= 1'b0;
                        t     <= p0;
                        a     <= KEY_W'(1);
                        kidx  <= '0;
`ifdef RSA_EARLY_EXIT_EN
                        state <= (e == '0) ? FINISH : LOOP;
`else
                        state <= LOOP;
`endif
                    end
                end
                LOOP: begin
                    if (go1) begin
                        mm_on <= 1'b1;
                    end else if (rdy0 && rdy1) begin
                        mm_on <= 1'b0;
                        t     <= p1;
                        if (e[kidx]) begin
                            a <= p0;
                        end
                        if (last_pass) begin
                            state <= FINISH;
                        end else begin
                            kidx <= kidx + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r     <= a;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed bench for rsa_modexp_core at KEY_W=16 with hand-computed vectors.
module tb_rsa_modexp_core;

    localparam logic [1:0] SEL_R = 2'd0;
    localparam logic [1:0] SEL_M = 2'd1;
    localparam logic [1:0] SEL_E = 2'd2;
    localparam logic [1:0] SEL_N = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b1;
    logic       oe = 1'b1;
    logic [1:0] reg_sel = 2'd0;
    logic [5:0] addr = 6'd0;
    logic [7:0] data_i = 8'd0;
    logic [7:0] data_o;
    logic       start = 1'b0;
    logic       busy, done, err;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_r;

    rsa_modexp_core #(.KEY_W(16), .DATA_W(8), .ADDR_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .oe      (oe),
        .reg_sel (reg_sel),
        .addr    (addr),
        .data_i  (data_i),
        .data_o  (data_o),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [15:0] ev);
        int  msb_p;
        bit  early;
        msb_p = 0;
        for (int i = 0; i < 16; i++) if (ev[i]) msb_p = i + 1;
`ifdef RSA_EARLY_EXIT_EN
        early = 1'b1;
`else
        early = 1'b0;
`endif
        return 2 * 16 + 9 * (1 + (early ? msb_p : 16)) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] sel, input logic [5:0] ad, input logic [7:0] d);
        reg_sel = sel;
        addr    = ad;
        data_i  = d;
        we      = 1'b0;
        tick();
        we      = 1'b1;
    endtask

    task automatic write_word(input logic [1:0] sel, input logic [15:0] v);
        write_reg(sel, 6'd0, v[7:0]);
        write_reg(sel, 6'd1, v[15:8]);
    endtask

    task automatic read_reg(input logic [1:0] sel, input logic [5:0] ad, output logic [7:0] d);
        reg_sel = sel;
        addr    = ad;
        oe      = 1'b0;
        tick();
        d       = data_o;
        oe      = 1'b1;
    endtask

    task automatic read_word(input logic [1:0] sel, output logic [15:0] v);
        logic [7:0] lo, hi;
        read_reg(sel, 6'd0, lo);
        read_reg(sel, 6'd1, hi);
        v = {hi, lo};
    endtask

    task automatic wait_done(inout int cyc);
        while (!done && cyc < 2000) begin
            tick();
            cyc++;
        end
    endtask

    // Full valid run: load, start, time done, read R against the scoreboard.
    task automatic run_op(input string tag, input logic [15:0] mv, input logic [15:0] ev,
                          input logic [15:0] nv, input logic [15:0] rv);
        int          cyc;
        logic [15:0] got, exp_r;
        write_word(SEL_M, mv);
        write_word(SEL_E, ev);
        write_word(SEL_N, nv);
        exp_q.push_back(rv);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        cyc = 0;
        wait_done(cyc);
        check({tag, "_lat"}, cyc, exp_latency(ev));
        check({tag, "_busy_clr"}, busy, 1'b0);
        tick();
        check({tag, "_done_1cyc"}, done, 1'b0);
        read_word(SEL_R, got);
        exp_r = exp_q.pop_front();
        check({tag, "_r"}, got, exp_r);
        last_r = exp_r;
    endtask

    // Rejected operands: err at once, done one cycle later, R untouched.
    task automatic run_invalid(input string tag, input logic [15:0] mv, input logic [15:0] nv);
        logic [15:0] got;
        write_word(SEL_M, mv);
        write_word(SEL_N, nv);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_err"}, err, 1'b1);
        check({tag, "_busy0"}, busy, 1'b0);
        check({tag, "_done_early"}, done, 1'b0);
        tick();
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy1"}, busy, 1'b0);
        tick();
        check({tag, "_done_drop"}, done, 1'b0);
        read_word(SEL_R, got);
        check({tag, "_r_kept"}, got, last_r);
    endtask

    initial begin
        logic [15:0] v;
        logic [7:0]  b;
        int          cyc;

        // Reset
        last_r = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_data_o", data_o, 8'h00);
        read_word(SEL_R, v);
        check("rst_r", v, 16'h0000);

        // Textbook RSA pair, byte-level readback of R
        run_op("enc", 16'd65, 16'd17, 16'd3233, 16'd2790);
        read_reg(SEL_R, 6'd0, b);
        check("r_byte0", b, 8'hE6);
        read_reg(SEL_R, 6'd1, b);
        check("r_byte1", b, 8'h0A);
        read_reg(SEL_R, 6'd2, b);
        check("r_addr_oob", b, 8'h00);
        read_word(SEL_N, v);
        check("n_readback", v, 16'd3233);

        // Operand validation
        run_invalid("inv_even", 16'd65, 16'd3232);
        run_invalid("inv_n1", 16'd0, 16'd1);
        run_invalid("inv_m_eq_n", 16'd3233, 16'd3233);

        // A valid start clears err
        run_op("dec", 16'd2790, 16'd2753, 16'd3233, 16'd65);
        check("err_cleared", err, 1'b0);

        // Ignored writes: R is read-only, out-of-range word index
        write_reg(SEL_R, 6'd0, 8'h55);
        read_word(SEL_R, v);
        check("r_write_ignored", v, 16'd65);
        write_reg(SEL_M, 6'd2, 8'h77);
        read_word(SEL_M, v);
        check("m_oob_write", v, 16'd2790);

        // Exponent and modulus corner cases
        run_op("e_zero", 16'd123, 16'd0, 16'd3233, 16'd1);
        run_op("pow10", 16'd2, 16'd10, 16'd3233, 16'd1024);
        run_op("pow5", 16'd3, 16'd5, 16'd3233, 16'd243);
        run_op("m_zero", 16'd0, 16'd5, 16'd3233, 16'd0);
        run_op("n_min", 16'd2, 16'd3, 16'd3, 16'd2);
        run_op("n_max_wrap", 16'd2, 16'd16, 16'd65535, 16'd1);
        run_op("n_max_15", 16'd2, 16'd15, 16'd65535, 16'd32768);
        run_op("m_neg1_sq", 16'd65534, 16'd2, 16'd65535, 16'd1);
        run_op("e_topbit", 16'd2, 16'h8001, 16'd65535, 16'd2);
        run_op("e_ones", 16'd1, 16'hFFFF, 16'd3233, 16'd1);

        // Writes and a second start while busy are ignored
        write_word(SEL_M, 16'd65);
        write_word(SEL_E, 16'd17);
        write_word(SEL_N, 16'd3233);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        repeat (50) begin
            tick();
            cyc++;
        end
        write_reg(SEL_N, 6'd0, 8'h00);
        cyc++;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc++;
        wait_done(cyc);
        check("busy_lat", cyc, exp_latency(16'd17));
        tick();
        read_word(SEL_R, v);
        check("busy_r", v, 16'd2790);
        read_word(SEL_N, v);
        check("busy_n_kept", v, 16'd3233);

        // Reset in the middle of LOOP aborts at once
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        check("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_data_o", data_o, 8'h00);
        tick();
        reset = 1'b0;
        read_word(SEL_R, v);
        check("mid_rst_r", v, 16'h0000);
        read_word(SEL_M, v);
        check("mid_rst_m", v, 16'h0000);
        run_op("rerun", 16'd65, 16'd17, 16'd3233, 16'd2790);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_core.md
Name: rsa_modexp_core

Overview:
Parametrised radix-4 Montgomery modular exponentiator computing R = M^E mod N for any KEY_W. It is the generalised successor of the team's fixed 256-bit RSA engine. Host access is a byte-wide register port: write M, E and N, pulse start, wait for done, then read R. It adds explicit start/busy/done/err handshaking, operand validation and a selectable loop-termination mode.

Parameters:
KEY_W, 256, operand width in bits; multiple of DATA_W, >= 16, even
DATA_W, 8, host data bus width
ADDR_W, 6, host word-address width; requires KEY_W/DATA_W <= 2**ADDR_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
we  in  1  active-low write strobe
oe  in  1  active-low read strobe
reg_sel  in  2  0=R (read-only), 1=M, 2=E, 3=N
addr  in  ADDR_W  word index, word 0 = least-significant
data_i  in  DATA_W  write data
data_o  out  DATA_W  registered read data
start  in  1  active-high; sampled only in IDLE
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse; R valid
err  out  1  sticky invalid-operand flag; cleared by the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. On reset: M, E, N, R = 0; data_o = 0; busy = done = err = 0; FSM -> IDLE.
- Register writes:
  - Occur when we=0 and busy=0. Writes while busy are ignored.
  - addr >= KEY_W/DATA_W: write ignored.
  - reg_sel=0 writes are ignored.
- Register reads:
  - When oe=0, data_o <= selected word on the next edge (1-cycle latency).
  - reg_sel/addr out of range: data_o <= 0.
  - Reads are allowed while busy; R holds its last value until it is updated.
- FSM states: IDLE, PRECOMP, CONVERT, LOOP, FINISH.
- IDLE:
  - start=1 -> validation, evaluated combinationally.
  - Invalid if N[0]=0, N<3, or M>=N. Invalid -> err<=1, done pulses next cycle, R unchanged, stay IDLE.
  - Valid -> busy<=1, go to PRECOMP.
- PRECOMP (2*KEY_W cycles):
  - Starts from C=1.
  - Each cycle: C <= (2C >= N) ? 2C-N : 2C.
  - Result is C = 2^(2*KEY_W) mod N.
- CONVERT:
  - Computes T = MM(C, M) and sets A = 1.
  - MM(x,y) = x*y*2^-KEY_W mod N, fully reduced.
- Montgomery multiply MM, cycle-accurate:
  - KEY_W/2 iterations, each consuming 2 bits of x, LSB first.
  - S <= (S + x_i*y + q*N) >> 2, where q = (-(S + x_i*y)*N[1:0]) mod 4.
  - One final conditional-subtract cycle.
  - Total KEY_W/2+1 cycles.
  - Intermediate width KEY_W+3; no overflow permitted.
- LOOP (one pass per exponent bit k = 0..KEY_W-1, each KEY_W/2+1 cycles):
  - A <= E[k] ? MM(A,T) : A and T <= MM(T,T), computed in parallel.
  - A stays in the normal domain, so no final conversion is needed.
- FINISH: R <= A; done pulses 1 cycle; busy<=0 in the same cycle; -> IDLE.
- Latency (valid operands, full loop): done asserts exactly 2*KEY_W + (KEY_W+1)*(KEY_W/2+1) + 1 cycles after the start sample edge. KEY_W=16 -> 186.
- Edge cases:
  - E=0 -> R=1.
  - start while busy -> ignored.
  - Reset mid-operation aborts immediately; R=0.

Optional Feature:
RSA_EARLY_EXIT_EN
- Defined: LOOP ends after the pass for the highest set bit of E; E=0 skips LOOP entirely (R=1). Latency depends on E.
- Undefined: all KEY_W passes always run, giving constant-time operation and fixed latency as stated above.

Decomposition:
- Package rsa_pkg:
  - state enum: IDLE, PRECOMP, CONVERT, LOOP, FINISH
  - reg_sel constants: REG_R=0, REG_M=1, REG_E=2, REG_N=3
  - localparams NWORDS = KEY_W/DATA_W and MM_CYC = KEY_W/2+1
- Sub-module rsa_mont_mul: parametrised by KEY_W, with go/rdy handshake, inputs x, y, n and output p.
  - Two instances.
  - Instance 0 is shared by CONVERT and A-update.
  - Instance 1 handles T-squaring.

Test Plan:
- KEY_W=16; N=3233, E=17, M=65, pulse start -> done at cycle 186; R reads 0x0AE6 (2790); bytes E6, 0A.
- Same N, E=2753, M=2790 -> R=65 (0x0041).
- E=0, M=123, N=3233 -> R=1. With RSA_EARLY_EXIT_EN -> done at cycle 2*16+9+1=42.
- N=3232 (even), start -> err=1, done pulse 1 cycle later, busy never high, R unchanged. The next valid start clears err.
- Writes during busy to N, and a second start during busy -> both ignored; result is identical to the first run.
- KEY_W=256 random odd N with M<N, 50 vectors vs golden model. Assert reset mid-LOOP -> busy=0, R=0 immediately; a rerun is correct.
